// File: rtl/bcd_display_scanner_pkg.sv
// Shared types and constants for the two-digit multiplexed BCD display scanner.
package bcd_display_scanner_pkg;

  // Display scan phases, visited in declaration order each frame.
  typedef enum logic [1:0] {
    S_ONES    = 2'd0,
    S_BLANK_O = 2'd1,
    S_TENS    = 2'd2,
    S_BLANK_T = 2'd3
  } state_t;

  // A BCD digit pair as carried between the handshake slot and the display.
  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } digits_t;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 7;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;

  // 16-entry digit encoding; non-BCD codes show a dash.
  function automatic logic [SEG_W-1:0] seg_encode(input logic [DIGIT_W-1:0] digit);
    logic [SEG_W-1:0] seg;
    seg = SEG_DASH;
    case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_display_scanner_seg.sv
// Combinational 4-bit digit to active-low seven-segment encoder.
module bcd_to_seven_seg
  import bcd_display_scanner_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg_n_c
);

  // Pure table lookup; codes above 9 map to a dash.
  always_comb begin
    seg_n_c = seg_encode(digit);
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Two-digit common-anode display scanner with frame-aligned value update.
module bcd_display_scanner
  import bcd_display_scanner_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_val,
  output logic       in_rdy,
  input  logic [3:0] in_tens,
  input  logic [3:0] in_ones,
  input  logic       blank_lz,
  output logic [6:0] seg_n,
  output logic [1:0] an_n,
  output logic       frame_done
);

  localparam int unsigned MAX_LEN = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;
  logic             frame_end;

  digits_t          disp;
  digits_t          pend;
  logic             pend_full;
  logic             accept;

  logic [3:0]       cur_digit;
  logic [6:0]       cur_seg_n;
  logic             tens_blank;

  // Last cycle of the current phase: dwell phases and gap phases differ in length.
  always_comb begin
    cnt_last = 1'b0;
    case (state)
      S_ONES, S_TENS:        cnt_last = (cnt == DWELL_LAST);
      S_BLANK_O, S_BLANK_T:  cnt_last = (cnt == BLANK_LAST);
      default:               cnt_last = 1'b0;
    endcase
  end

  // The frame ends on the final cycle of the tens-side gap.
  assign frame_end = (state == S_BLANK_T) && cnt_last;

  // Phase register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_ONES;
    end else begin
      state <= state_next;
    end
  end

  // Advance around the ring once the current phase has run its length.
  always_comb begin
    state_next = state;
    if (cnt_last) begin
      case (state)
        S_ONES:    state_next = S_BLANK_O;
        S_BLANK_O: state_next = S_TENS;
        S_TENS:    state_next = S_BLANK_T;
        S_BLANK_T: state_next = S_ONES;
        default:   state_next = S_ONES;
      endcase
    end
  end

  // Cycle count within the current phase, restarting on every phase change.
  always_ff @(posedge clk) begin
    if (rst || cnt_last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Slot is offered only when empty and out of reset.
  assign in_rdy = !pend_full && !rst;
  assign accept = in_val && in_rdy;

  // Pending slot and displayed pair; the swap happens only at a frame boundary,
  // where the slot is necessarily full-or-empty without a same-cycle accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp      <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
    end else if (frame_end && pend_full) begin
      disp      <= pend;
      pend_full <= 1'b0;
    end else if (accept) begin
      pend.tens <= in_tens;
      pend.ones <= in_ones;
      pend_full <= 1'b1;
    end
  end

  // Single encoder shared by both digit positions.
  assign cur_digit = (state == S_TENS) ? disp.tens : disp.ones;

  bcd_to_seven_seg u_enc (
    .digit   (cur_digit),
    .seg_n_c (cur_seg_n)
  );

  // Leading-zero blanking follows blank_lz live, without latching.
  assign tens_blank = blank_lz && (disp.tens == 4'd0);

  // Drive anodes and segments from the phase; everything dark during reset.
  always_comb begin
    an_n       = 2'b11;
    seg_n      = SEG_BLANK;
    frame_done = 1'b0;
    if (!rst) begin
      frame_done = frame_end;
      case (state)
        S_ONES: begin
          an_n  = 2'b10;
          seg_n = cur_seg_n;
        end
        S_TENS: begin
          if (!tens_blank) begin
            an_n  = 2'b01;
            seg_n = cur_seg_n;
          end
        end
        default: begin
          an_n  = 2'b11;
          seg_n = SEG_BLANK;
        end
      endcase
    end
  end

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
- Downstream consumer of the binary-to-BCD converter's tens/ones digits.
- Drives a two-digit, common-anode, time-multiplexed seven-segment display.
- Holds one pending value through a valid/ready input handshake and swaps it in only at a frame boundary, so a frame never mixes old and new digits.
- Each digit is shown for a dwell period, separated by blanking gaps to prevent ghosting; the tens digit supports optional leading-zero blanking.

Parameters:
DWELL_CYCLES, 1000, cycles each digit is driven (must be >= 1)
BLANK_CYCLES, 16, cycles of all-off gap after each digit (must be >= 1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
in_val  input  1  new digit pair offered
in_rdy  output  1  pending slot free; transfer occurs when in_val && in_rdy
in_tens  input  4  BCD tens digit
in_ones  input  4  BCD ones digit
blank_lz  input  1  when 1, a tens digit of 0 is shown blank
seg_n  output  7  active-low segments {g,f,e,d,c,b,a}
an_n  output  2  active-low digit enables: [1]=tens, [0]=ones
frame_done  output  1  one-cycle pulse on the last cycle of each frame

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset, sampled on a clk edge with rst=1:
  - state=S_ONES, dwell counter=0.
  - displayed digits = 0/0; pending register = 0/0; pend_full=0.
- Outputs while rst=1: seg_n=7'h7F, an_n=2'b11, frame_done=0, in_rdy=0.
- First cycle after reset: S_ONES showing digit 0 (seg_n=7'h40, an_n=2'b10).
- FSM states: S_ONES -> S_BLANK_O -> S_TENS -> S_BLANK_T -> S_ONES.
  - S_ONES and S_TENS last DWELL_CYCLES each; S_BLANK_O and S_BLANK_T last BLANK_CYCLES each.
  - Frame length = 2*(DWELL_CYCLES+BLANK_CYCLES) cycles.
  - A single counter counts 0..len-1 within the current state; it resets to 0 on each state change.
  - Counter width = $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1).
- Outputs are combinational from state plus displayed registers (zero latency within a state):
  - S_ONES: an_n=2'b10, seg_n=enc(ones).
  - S_TENS: an_n=2'b01, seg_n=enc(tens).
    - If blank_lz=1 and tens==0: an_n=2'b11, seg_n=7'h7F.
  - Blank states: an_n=2'b11, seg_n=7'h7F.
- Encoder, active-low:
  - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex).
  - Codes 10..15 display dash = 7'h3F.
- Handshake:
  - in_rdy = !pend_full.
  - Transfer at a clk edge: pending<=inputs, pend_full<=1.
  - in_val held with in_rdy=0 is ignored; there is no overwrite.
- Frame boundary = last cycle of S_BLANK_T; frame_done=1 on exactly that cycle.
  - At this edge, if pend_full: displayed<=pending, pend_full<=0.
  - The new value is visible from the first S_ONES cycle.
  - in_rdy is still 0 during the boundary cycle, so there is no simultaneous accept; in_rdy returns to 1 the next cycle.
- blank_lz is not latched and takes effect combinationally.
- rst mid-frame: immediate return to reset values at the next edge; any pending value is discarded.

Decomposition:
- Shared package: state enum (S_ONES, S_BLANK_O, S_TENS, S_BLANK_T), constants SEG_BLANK=7'h7F and SEG_DASH=7'h3F, the 16-entry digit encoding.
- One sub-module, bcd_to_seven_seg (combinational 4-bit to 7-bit active-low encoder), instantiated once on a mux of the displayed digits.

Test Plan (DWELL_CYCLES=4, BLANK_CYCLES=2, frame = 12 cycles):
1. Reset, then idle -> outputs follow a 12-cycle frame:
   - 4 cycles an_n=10, seg_n=40; 2 cycles 11/7F; 4 cycles 01/40; 2 cycles 11/7F.
   - frame_done high on cycle 12 only.
2. In S_ONES cycle 1, in_val with tens=2, ones=7:
   - in_rdy drops the next cycle; the current frame still shows 0/0.
   - Next frame shows ones seg_n=78 and tens seg_n=24; in_rdy=1 after the boundary.
3. Second in_val (tens=1, ones=5) while pend_full -> ignored; the displayed value after the boundary is the first one offered.
4. Load 0/9 with blank_lz=1 -> tens slot an_n=11, seg_n=7F; with blank_lz=0 -> an_n=01, seg_n=40.
5. Load tens=3, ones=12 -> ones slot seg_n=3F (dash), tens seg_n=30.
6. Assert rst during S_TENS with pend_full=1:
   - Outputs go to 11/7F and in_rdy=0 while rst is high.
   - After release: S_ONES with digit 0; pending value discarded; in_rdy=1.
